// File: rtl/bcd_scan_display_pkg.sv
// Shared seven-segment constants for the multiplexed BCD display.
// Codes are active-high gfedcba; the display top inverts them for the active-low pins.
package bcd_scan_display_pkg;

  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-high gfedcba segment pattern; codes 10..15 show a dash.
module bcd_to_seg7
  import bcd_scan_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (bcd_i <= 4'd9) seg_o = SEG_DIGIT[bcd_i];
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed scan of NDIG snapshotted BCD digits onto one active-low
// seven-segment bus, with leading-zero blanking and a per-scan frame pulse.
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int DIV  = 50000,
  parameter int NDIG = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic              load,
  input  logic              blank_lz,
  input  logic [NDIG-1:0]   dp_mask,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [4*NDIG-1:0] snap_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, wrap_q, frame_q;

  logic              tick;
  logic [3:0]        digit;
  logic [6:0]        seg_raw;
  logic [NDIG-1:0]   zero_from;
  logic              blank;

  assign tick  = (cnt_q == CW'(DIV - 1));
  assign digit = snap_q[4*idx_q +: 4];

  bcd_to_seg7 u_dec (
    .bcd_i (digit),
    .seg_o (seg_raw)
  );

  // zero_from[i]: every snapshot digit from the top down to i is zero
  always_comb begin
    logic run;
    run = 1'b1;
    zero_from = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      run = run & (snap_q[4*i +: 4] == 4'd0);
      zero_from[i] = run;
    end
  end

  assign blank = blank_lz && (idx_q != '0) && zero_from[idx_q];

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    an_d = '1;
    an_d[idx_q] = 1'b0;
    seg_d = ~(blank ? SEG_BLANK : seg_raw);
  end

  // Outputs sample the pre-edge snap/idx, so a load coinciding with a tick
  // only becomes visible from the following edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      wrap_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      if (load) snap_q <= bcd_in;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= ~dp_mask[idx_q];
      wrap_q  <= tick && (idx_q == IW'(NDIG - 1));
      frame_q <= wrap_q;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed self-checking bench for bcd_scan_display with DIV=4, NDIG=6.
module tb_bcd_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic [5:0]  dp_mask;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_scan_display #(.DIV(4), .NDIG(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .bcd_in   (bcd_in),
    .load     (load),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      n++;
      if (frame) break;
    end
    if (!frame) chk({tag, " frame timeout"}, 32'd0, 32'd1);
  endtask

  task automatic load_snap(input logic [23:0] v);
    bcd_in = v;
    load   = 1'b1;
    step(1);
    load   = 1'b0;
  endtask

  // segs packs expected seg per digit {d5..d0}; dps is expected dp per digit
  task automatic scan(input string tag, input logic [41:0] segs, input logic [5:0] dps);
    int n;
    logic [5:0] an_exp;
    wait_frame(tag, n);
    for (int k = 0; k < 6; k++) begin
      an_exp = ~(6'b000001 << k);
      chk($sformatf("%s an d%0d", tag, k), 32'(an), 32'(an_exp));
      chk($sformatf("%s seg d%0d", tag, k), 32'(seg), 32'(segs[7*k +: 7]));
      chk($sformatf("%s dp d%0d", tag, k), 32'(dp), 32'(dps[k]));
      if (k == 1) chk({tag, " frame low"}, 32'(frame), 32'd0);
      step(4);
    end
    chk({tag, " frame period"}, 32'(frame), 32'd1);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    load     = 1'b1;
    bcd_in   = 24'h123456;
    blank_lz = 1'b0;
    dp_mask  = 6'b000000;
    step(3);
    chk("rst an", 32'(an), 32'h3F);
    chk("rst seg", 32'(seg), 32'h7F);
    chk("rst dp", 32'(dp), 32'd1);
    chk("rst frame", 32'(frame), 32'd0);

    // load held through reset must be ignored; first free edge shows digit 0
    reset = 1'b0;
    load  = 1'b0;
    step(1);
    chk("first an", 32'(an), 32'h3E);
    chk("first seg", 32'(seg), 32'h40);

    load_snap(24'h123456);
    bcd_in = 24'h999999;
    scan("s123456", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 6'h3F);

    blank_lz = 1'b1;
    load_snap(24'h000705);
    scan("lz0705", {7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h12}, 6'h3F);

    blank_lz = 1'b0;
    dp_mask  = 6'b000100;
    load_snap(24'h00000F);
    scan("dashF", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F}, 6'b111011);

    step(8);
    chk("dp live an", 32'(an), 32'h3B);
    chk("dp live on", 32'(dp), 32'd0);
    dp_mask = 6'b000000;
    step(1);
    chk("dp live off", 32'(dp), 32'd1);

    load_snap(24'h000000);
    wait_frame("tickload", n);
    step(2);
    bcd_in = 24'h000009;
    load   = 1'b1;
    step(1);
    load   = 1'b0;
    chk("tickload an", 32'(an), 32'h3E);
    chk("tickload old", 32'(seg), 32'h40);
    step(1);
    chk("tickload adv", 32'(an), 32'h3D);
    scan("tickload new", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10}, 6'h3F);

    dp_mask = 6'b001000;
    step(12);
    chk("mid an d3", 32'(an), 32'h37);
    chk("mid dp d3", 32'(dp), 32'd0);
    reset = 1'b1;
    step(1);
    chk("midrst an", 32'(an), 32'h3F);
    chk("midrst seg", 32'(seg), 32'h7F);
    chk("midrst dp", 32'(dp), 32'd1);
    chk("midrst frame", 32'(frame), 32'd0);
    step(1);
    reset = 1'b0;
    step(1);
    chk("restart an", 32'(an), 32'h3E);
    chk("restart seg", 32'(seg), 32'h40);
    chk("restart frame", 32'(frame), 32'd0);
    wait_frame("restart", n);
    chk("restart frame delay", 32'(n), 32'd24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
